alu_shift_sequencer: RTL
========================

Name: alu_shift_sequencer

Overview:
- Multi-cycle shift engine for the KNIPS 8-bit datapath.
- Acts as the initiator to the combinational ALU, which is the responder. It performs an N-bit shift by issuing N single-bit shift operations (left or right, through carry) to the ALU, one per clock.
- Each step feeds the ALU result back as the next INPUTA.
- Requests arrive from the control unit over a valid/ready handshake. The result, last shifted-out bit and zero flag are returned over a second valid/ready handshake.

Parameters:
- W, 8: data width; matches ALU INPUTA/OUT.
- AW, 4: shift-amount width; amounts 0..15.
- OPW, 5: ALU opcode width.
- OP_LSH, 5'h01: ALU opcode for 1-bit left shift; ALU computes {SC_OUT,OUT} = {INPUTA,SC_IN}.
- OP_RSH, 5'h02: ALU opcode for 1-bit right shift; ALU computes {OUT,SC_OUT} = {SC_IN,INPUTA}.
- OP_NOP, 5'h00: opcode driven while not shifting.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  reset, synchronous, active-low.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  sequencer can accept a request.
- REQ_DATA  in  W  value to shift.
- REQ_AMT  in  AW  number of bit positions.
- REQ_DIR  in  1  0 = right, 1 = left.
- REQ_FILL  in  1  bit shifted in on every step.
- ALU_OP  out  OPW  opcode to ALU.
- ALU_INPUTA  out  W  operand to ALU.
- ALU_INPUTB  out  W  driven 0.
- ALU_SC_IN  out  1  shift-in bit to ALU.
- ALU_OUT  in  W  ALU result, same cycle.
- ALU_SC_OUT  in  1  ALU shift-out bit, same cycle.
- RES_VALID  out  1  result valid.
- RES_READY  in  1  consumer accepts result.
- RES_DATA  out  W  shifted value.
- RES_CARRY  out  1  last bit shifted out.
- RES_ZERO  out  1  RES_DATA == 0.
- BUSY  out  1  high in SHIFT or DONE.

Behaviour:
- Reset: all state changes on the rising edge of CLK. RESET_N low at an edge forces:
  - state=IDLE; acc=0; cnt=0; carry=0.
  - REQ_READY=1 after reset releases; RES_VALID=0; RES_DATA=0; RES_CARRY=0; RES_ZERO=1; BUSY=0.
  - ALU_OP=OP_NOP; ALU_INPUTA=0; ALU_SC_IN=0; ALU_INPUTB=0.
  - Reset mid-operation discards the in-flight request; no RES_VALID is produced for it.
- Registers: acc[W-1:0], cnt[AW-1:0], dir, fill, carry.
- State IDLE:
  - REQ_READY=1.
  - On REQ_VALID at an edge: acc<=REQ_DATA, cnt<=REQ_AMT, dir/fill latched, carry<=0.
  - Next state is SHIFT if REQ_AMT!=0, else DONE.
- State SHIFT:
  - REQ_READY=0.
  - ALU driven combinationally: ALU_OP = dir ? OP_LSH : OP_RSH; ALU_INPUTA=acc; ALU_SC_IN=fill.
  - Each edge: acc<=ALU_OUT; carry<=ALU_SC_OUT; cnt<=cnt-1.
  - When cnt==1 at the edge, go to DONE.
  - Exactly N SHIFT cycles for amount N.
- State DONE:
  - RES_VALID=1; RES_DATA=acc; RES_CARRY=carry; RES_ZERO=(acc==0); ALU_OP=OP_NOP.
  - Outputs are held stable until RES_READY=1 at an edge, then go to IDLE.
  - No new request is accepted in the same cycle; a back-to-back request is accepted no earlier than the cycle after the DONE to IDLE transition.
- Latency: accept edge to RES_VALID high is N+1 cycles for N>0, and 1 cycle for N=0.
- Amount 0: RES_DATA=REQ_DATA, RES_CARRY=0, no ALU op issued.
- Amounts greater than W: stepping continues. Once all original bits are gone, every extra step shifts fill in and shifts fill out, so for N>W: RES_DATA = all fill bits, RES_CARRY = fill.
- REQ_DATA/REQ_AMT/REQ_DIR/REQ_FILL are sampled only at the accept edge; later changes are ignored.
- Only one request is outstanding at a time; no queueing.
- ALU_INPUTB is constant 0 in all states.

Test Plan:
- Reset, then left shift REQ_DATA=8'hB3, AMT=1, DIR=1, FILL=1 -> exactly 1 SHIFT cycle with ALU_OP=OP_LSH, ALU_INPUTA=8'hB3, ALU_SC_IN=1; RES_VALID 2 cycles after accept; RES_DATA=8'h67, RES_CARRY=1, RES_ZERO=0.
- Right shift 8'hB3, AMT=3, DIR=0, FILL=0 -> ALU_INPUTA sequence B3, 59, 2C; RES_DATA=8'h16, RES_CARRY=0; RES_VALID 4 cycles after accept.
- AMT=0, REQ_DATA=8'h5A -> ALU_OP stays OP_NOP; RES_VALID 1 cycle after accept; RES_DATA=8'h5A, RES_CARRY=0.
- Left shift 8'h81, AMT=8, FILL=0 -> RES_DATA=8'h00, RES_CARRY=1, RES_ZERO=1. Then right shift 8'h00, AMT=12, FILL=1 -> RES_DATA=8'hFF, RES_CARRY=1.
- Backpressure: hold RES_READY=0 for 5 cycles after RES_VALID -> RES_* stable, REQ_READY=0 throughout. RES_READY=1 -> REQ_READY=1 the next cycle; a queued REQ_VALID is accepted then.
- RESET_N low for 1 cycle during the 2nd SHIFT cycle of AMT=6 -> next cycle: IDLE, REQ_READY=1, RES_VALID=0, ALU_OP=OP_NOP; no stale result ever appears.

Source files
------------

// File: rtl/alu_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_shift_sequencer
// Function : Multi-cycle N-bit shifter that drives one 1-bit shift through
//            the combinational ALU on each clock, feeding the result back.
// Revision : 1.0  initial release
// ============================================================================
module alu_shift_sequencer #(
    parameter int             W      = 8,
    parameter int             AW     = 4,
    parameter int             OPW    = 5,
    parameter logic [OPW-1:0] OP_LSH = 5'h01,
    parameter logic [OPW-1:0] OP_RSH = 5'h02,
    parameter logic [OPW-1:0] OP_NOP = 5'h00
) (
    input  logic           CLK,
    input  logic           RESET_N,
    // request from control unit
    input  logic           REQ_VALID,
    output logic           REQ_READY,
    input  logic [W-1:0]   REQ_DATA,
    input  logic [AW-1:0]  REQ_AMT,
    input  logic           REQ_DIR,
    input  logic           REQ_FILL,
    // ALU (responder)
    output logic [OPW-1:0] ALU_OP,
    output logic [W-1:0]   ALU_INPUTA,
    output logic [W-1:0]   ALU_INPUTB,
    output logic           ALU_SC_IN,
    input  logic [W-1:0]   ALU_OUT,
    input  logic           ALU_SC_OUT,
    // result to consumer
    output logic           RES_VALID,
    input  logic           RES_READY,
    output logic [W-1:0]   RES_DATA,
    output logic           RES_CARRY,
    output logic           RES_ZERO,
    output logic           BUSY
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic           dir_q, dir_d;
    logic           fill_q, fill_d;
    logic           carry_q, carry_d;
    logic           req_ready_q, req_ready_d;
    logic           res_valid_q, res_valid_d;
    logic           busy_q, busy_d;
    logic           zero_q, zero_d;
    logic           w_shifting;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        fill_d  = fill_q;
        carry_d = carry_q;
        case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    acc_d   = REQ_DATA;
                    cnt_d   = REQ_AMT;
                    dir_d   = REQ_DIR;
                    fill_d  = REQ_FILL;
                    carry_d = 1'b0;
                    state_d = (REQ_AMT != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                acc_d   = ALU_OUT;
                carry_d = ALU_SC_OUT;
                cnt_d   = cnt_q - AW'(1);
                if (cnt_q == AW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (RES_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake/status outputs are registered from the next state.
        req_ready_d = (state_d == S_IDLE);
        res_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
        zero_d      = (acc_d == '0);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            fill_q      <= 1'b0;
            carry_q     <= 1'b0;
            req_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            fill_q      <= fill_d;
            carry_q     <= carry_d;
            req_ready_q <= req_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            zero_q      <= zero_d;
        end
    end

    // The ALU is only engaged while stepping; otherwise it sees a quiet NOP.
    assign w_shifting = (state_q == S_SHIFT);
    assign ALU_OP     = w_shifting ? (dir_q ? OP_LSH : OP_RSH) : OP_NOP;
    assign ALU_INPUTA = w_shifting ? acc_q : '0;
    assign ALU_SC_IN  = w_shifting ? fill_q : 1'b0;
    assign ALU_INPUTB = '0;

    assign REQ_READY  = req_ready_q;
    assign RES_VALID  = res_valid_q;
    assign RES_DATA   = acc_q;
    assign RES_CARRY  = carry_q;
    assign RES_ZERO   = zero_q;
    assign BUSY       = busy_q;

endmodule
`default_nettype wire
